// File: rtl/traffic_chk_if.sv
// traffic_chk_if: H2C stream bundle between the DMA (master) and the traffic checker (slave).
interface traffic_chk_if #(
    parameter int TX_LEN = 512,
    parameter int TX_BEN = TX_LEN / 8
);
    logic              tx_valid;
    logic [TX_LEN-1:0] tx_data;
    logic [TX_BEN-1:0] tx_ben;
    logic              tx_last;
    logic [10:0]       tx_qid;
    logic              tx_ready;

    modport master (
        output tx_valid, tx_data, tx_ben, tx_last, tx_qid,
        input  tx_ready
    );

    modport slave (
        input  tx_valid, tx_data, tx_ben, tx_last, tx_qid,
        output tx_ready
    );
endinterface

// File: rtl/traffic_chk.sv
// traffic_chk: checks a stream of generated test frames (header, 0x41 payload, "!!!\n" trailer),
// counting packets, bytes and bad packets per run. Byte lane i of tx_data holds frame byte
// beat*TX_BEN+i. Defining TRAFFIC_CHK_QID_CHECK_EN adds a per-beat check of tx_qid against a
// rotating expected queue id; without it tx_qid, qid and num_queue are ignored.
module traffic_chk #(
    parameter int TX_LEN  = 512,
    parameter int TX_BEN  = TX_LEN / 8,
    parameter int DST_NUM = 4
) (
    input  logic        axi_aclk,
    input  logic        axi_aresetn,
    input  logic [31:0] control_reg,
    input  logic [15:0] exp_size,
    input  logic [15:0] num_pkt,
    input  logic [10:0] qid,
    input  logic [10:0] num_queue,
    traffic_chk_if.slave txIf,
    output logic [15:0] pkt_count,
    output logic [15:0] err_count,
    output logic [31:0] byte_count,
    output logic        chk_done,
    output logic        err_flag
);
    typedef enum logic [1:0] {IDLE = 2'd0, HDR = 2'd1, BODY = 2'd2, DONE = 2'd3} state_t;

    localparam int              RR_W   = (DST_NUM > 1) ? $clog2(DST_NUM) : 1;
    localparam logic [RR_W-1:0] RR_MAX = RR_W'(DST_NUM - 1);

    state_t            state_q;
    logic              start_q;
    logic              txReady_q;
    logic              chkDone_q;
    logic              errFlag_q;
    logic              pktErr_q;
    logic [15:0]       beatIdx_q;
    logic [15:0]       pktCount_q;
    logic [15:0]       errCount_q;
    logic [31:0]       byteCount_q;
    logic [31:0]       frameBytes_q;
    logic [RR_W-1:0]   rr_q;

    logic              startPulse;
    logic              clearReq;
    logic              accept;
    logic              beatFinal;
    logic              benErr;
    logic              dataErr;
    logic              lenErr;
    logic              qidErr;
    logic              beatErr;
    logic              pktErrAll;
    logic              lastPkt;
    logic [15:0]       lastBeat;
    logic [15:0]       pktCount_d;
    logic [15:0]       errCount_d;
    logic [31:0]       byteCount_d;
    logic [31:0]       frameBytes_d;
    logic [31:0]       beatBase;
    logic [31:0]       beatBytes;
    logic [31:0]       remBytes;
    logic [31:0]       off;
    logic [32:0]       byteSum;
    logic [7:0]        expB;
    logic [TX_BEN-1:0] lastMask;
    logic [TX_BEN-1:0] benExp;
    logic [RR_W-1:0]   rr_d;

    // Expected value of frame byte b for destination index rr in a frame of len bytes.
    function automatic logic [7:0] expectedByte(input logic [31:0] b, input logic [RR_W-1:0] rr,
                                                input logic [15:0] len);
        logic [31:0] l;
        l = 32'(len);
        if (b < 32'd2)             return 8'h21;
        else if (b < 32'd8)        return 8'(b - 32'd1) * 8'h11;
        else if (b == 32'd8)       return 8'(rr) + 8'd1;
        else if (b < 32'd14)       return 8'h00;
        else if (b == l - 32'd1)   return 8'h0A;
        else if (b >= l - 32'd4)   return 8'h21;
        else                       return 8'h41;
    endfunction

    assign startPulse    = control_reg[1] & ~start_q;
    assign clearReq      = control_reg[2];
    assign accept        = txIf.tx_valid & txReady_q & ((state_q == HDR) || (state_q == BODY));
    assign txIf.tx_ready = txReady_q;
    assign pkt_count     = pktCount_q;
    assign err_count     = errCount_q;
    assign byte_count    = byteCount_q;
    assign chk_done      = chkDone_q;
    assign err_flag      = errFlag_q;

    logic unusedCtrl;
    assign unusedCtrl = ^{control_reg[31:3], control_reg[0]};

`ifdef TRAFFIC_CHK_QID_CHECK_EN
    logic [10:0] expQid_q;
    logic [10:0] qidLast;

    assign qidLast = qid + num_queue - 11'd1;
    assign qidErr  = (txIf.tx_qid != expQid_q);

    // Expected queue id: loads the base on start and rotates through the queue range per packet.
    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            expQid_q <= 11'd0;
        end else if (startPulse) begin
            expQid_q <= qid;
        end else if (accept && txIf.tx_last) begin
            expQid_q <= (expQid_q == qidLast) ? qid : expQid_q + 11'd1;
        end
    end
`else
    logic unusedQid;
    assign unusedQid = ^{qid, num_queue, txIf.tx_qid};
    assign qidErr    = 1'b0;
`endif

    // Per-beat checks: byte enables, byte contents, frame length, and the saturating next counts.
    always_comb begin
        lastBeat = 16'((32'(exp_size) - 32'd1) / 32'(TX_BEN));
        remBytes = 32'(exp_size) % 32'(TX_BEN);
        if (remBytes == 32'd0) begin
            remBytes = 32'(TX_BEN);
        end
        lastMask = '0;
        for (int i = 0; i < TX_BEN; i++) begin
            lastMask[i] = (32'(i) < remBytes);
        end
        beatFinal = (beatIdx_q == lastBeat);
        benExp    = beatFinal ? lastMask : '1;
        benErr    = (txIf.tx_ben != benExp);
        lenErr    = txIf.tx_last ? ~beatFinal : beatFinal;
        beatBase  = 32'(beatIdx_q) * 32'(TX_BEN);
        dataErr   = 1'b0;
        beatBytes = 32'd0;
        off       = 32'd0;
        expB      = 8'd0;
        for (int i = 0; i < TX_BEN; i++) begin
            off  = beatBase + 32'(i);
            expB = expectedByte(off, rr_q, exp_size);
            if (txIf.tx_ben[i]) begin
                beatBytes = beatBytes + 32'd1;
                if ((off < 32'(exp_size)) && (txIf.tx_data[8*i +: 8] != expB)) begin
                    dataErr = 1'b1;
                end
            end
        end
        beatErr      = benErr | dataErr | lenErr | qidErr;
        pktErrAll    = pktErr_q | beatErr;
        frameBytes_d = frameBytes_q + beatBytes;
        byteSum      = {1'b0, byteCount_q} + {1'b0, frameBytes_d};
        byteCount_d  = byteSum[32] ? 32'hFFFF_FFFF : byteSum[31:0];
        pktCount_d   = (pktCount_q == 16'hFFFF) ? pktCount_q : pktCount_q + 16'd1;
        errCount_d   = (pktErrAll && (errCount_q != 16'hFFFF)) ? errCount_q + 16'd1 : errCount_q;
        lastPkt      = ((17'(pktCount_q) + 17'd1) == 17'(num_pkt));
        rr_d         = (rr_q == RR_MAX) ? '0 : rr_q + RR_W'(1);
    end

    // Run control FSM with counters; start outranks a coincident beat and clear outranks frame end.
    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            state_q      <= IDLE;
            start_q      <= 1'b0;
            txReady_q    <= 1'b0;
            chkDone_q    <= 1'b0;
            errFlag_q    <= 1'b0;
            pktErr_q     <= 1'b0;
            beatIdx_q    <= 16'd0;
            pktCount_q   <= 16'd0;
            errCount_q   <= 16'd0;
            byteCount_q  <= 32'd0;
            frameBytes_q <= 32'd0;
            rr_q         <= '0;
        end else begin
            start_q <= control_reg[1];
            if (startPulse) begin
                pktCount_q   <= 16'd0;
                errCount_q   <= 16'd0;
                byteCount_q  <= 32'd0;
                frameBytes_q <= 32'd0;
                errFlag_q    <= 1'b0;
                pktErr_q     <= 1'b0;
                beatIdx_q    <= 16'd0;
                rr_q         <= '0;
                if (num_pkt == 16'd0) begin
                    state_q   <= DONE;
                    txReady_q <= 1'b0;
                    chkDone_q <= 1'b1;
                end else begin
                    state_q   <= HDR;
                    txReady_q <= 1'b1;
                    chkDone_q <= 1'b0;
                end
            end else begin
                if (accept) begin
                    if (beatErr) begin
                        errFlag_q <= 1'b1;
                    end
                    if (txIf.tx_last) begin
                        // A single-beat frame can also be the last packet, so HDR may finish the run too.
                        pktCount_q   <= pktCount_d;
                        errCount_q   <= errCount_d;
                        byteCount_q  <= byteCount_d;
                        frameBytes_q <= 32'd0;
                        pktErr_q     <= 1'b0;
                        beatIdx_q    <= 16'd0;
                        rr_q         <= rr_d;
                        if (lastPkt) begin
                            state_q   <= DONE;
                            txReady_q <= 1'b0;
                            chkDone_q <= 1'b1;
                        end else begin
                            state_q <= HDR;
                        end
                    end else begin
                        frameBytes_q <= frameBytes_d;
                        pktErr_q     <= pktErrAll;
                        beatIdx_q    <= (beatIdx_q == 16'hFFFF) ? beatIdx_q : beatIdx_q + 16'd1;
                        state_q      <= BODY;
                    end
                end
                if (clearReq) begin
                    pktCount_q  <= 16'd0;
                    errCount_q  <= 16'd0;
                    byteCount_q <= 32'd0;
                    errFlag_q   <= 1'b0;
                end
            end
        end
    end
endmodule

// File: tb/tb_traffic_chk.sv
// tb_traffic_chk: directed frame runs for traffic_chk; expected end-of-run counters are queued
// per run and compared by a monitor when chk_done rises. Reset behaviour is checked directly.
module tb_traffic_chk;
    localparam int TX_LEN = 512;
    localparam int TX_BEN = 64;

`ifdef TRAFFIC_CHK_QID_CHECK_EN
    localparam int QID_ERR = 1;
`else
    localparam int QID_ERR = 0;
`endif

    typedef struct {
        int runId;
        int pkt;
        int err;
        int bytes;
        int flag;
    } exp_t;

    logic        axi_aclk = 1'b0;
    logic        axi_aresetn = 1'b0;
    logic [31:0] control_reg;
    logic [15:0] exp_size;
    logic [15:0] num_pkt;
    logic [10:0] qid;
    logic [10:0] num_queue;
    logic [15:0] pkt_count;
    logic [15:0] err_count;
    logic [31:0] byte_count;
    logic        chk_done;
    logic        err_flag;
    logic        prevDone = 1'b0;

    int   checksTotal = 0;
    int   checksPassed = 0;
    exp_t sbQ[$];

    traffic_chk_if #(.TX_LEN(TX_LEN), .TX_BEN(TX_BEN)) txIf ();

    traffic_chk #(.TX_LEN(TX_LEN), .TX_BEN(TX_BEN), .DST_NUM(4)) dut (
        .axi_aclk    (axi_aclk),
        .axi_aresetn (axi_aresetn),
        .control_reg (control_reg),
        .exp_size    (exp_size),
        .num_pkt     (num_pkt),
        .qid         (qid),
        .num_queue   (num_queue),
        .txIf        (txIf),
        .pkt_count   (pkt_count),
        .err_count   (err_count),
        .byte_count  (byte_count),
        .chk_done    (chk_done),
        .err_flag    (err_flag)
    );

    always #5 axi_aclk = ~axi_aclk;

    // Frame byte model: header, destination byte, payload and trailer by offset.
    function automatic logic [7:0] expByte(input int offs, input int rr, input int len);
        case (offs)
            0, 1: return 8'h21;
            2:    return 8'h11;
            3:    return 8'h22;
            4:    return 8'h33;
            5:    return 8'h44;
            6:    return 8'h55;
            7:    return 8'h66;
            8:    return 8'(rr + 1);
            9, 10, 11, 12, 13: return 8'h00;
            default: begin
                if (offs == len - 1)      return 8'h0A;
                else if (offs >= len - 4) return 8'h21;
                else                      return 8'h41;
            end
        endcase
    endfunction

    function automatic logic [TX_LEN-1:0] buildData(input int rr, input int len, input int bt,
                                                    input int corruptOff, input logic [7:0] corruptVal);
        logic [TX_LEN-1:0] d;
        int offs;
        d = '0;
        for (int i = 0; i < TX_BEN; i++) begin
            offs = bt * TX_BEN + i;
            if (offs < len) d[8*i +: 8] = expByte(offs, rr, len);
            if (offs == corruptOff) d[8*i +: 8] = corruptVal;
        end
        return d;
    endfunction

    function automatic logic [TX_BEN-1:0] buildBen(input int len, input int bt);
        logic [TX_BEN-1:0] b;
        int total;
        int rem;
        total = (len + TX_BEN - 1) / TX_BEN;
        rem = len % TX_BEN;
        if (rem == 0) rem = TX_BEN;
        b = '1;
        if (bt == total - 1) begin
            b = '0;
            for (int i = 0; i < rem; i++) b[i] = 1'b1;
        end
        return b;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
        checksTotal++;
        if (act === expv) checksPassed++;
        else $display("[TB] FAIL %s: got %0d expected %0d", name, act, expv);
    endtask

    // Drives one beat from a negedge and returns at the negedge after it is accepted.
    task automatic applyStimulus(input logic [TX_LEN-1:0] d, input logic [TX_BEN-1:0] b,
                                 input logic last, input logic [10:0] q);
        int guard;
        txIf.tx_valid = 1'b1;
        txIf.tx_data  = d;
        txIf.tx_ben   = b;
        txIf.tx_last  = last;
        txIf.tx_qid   = q;
        guard = 0;
        while (!txIf.tx_ready && guard < 50) begin
            @(negedge axi_aclk);
            guard++;
        end
        if (guard >= 50) begin
            checksTotal++;
            $display("[TB] FAIL handshake_timeout: tx_ready %0d required 1", txIf.tx_ready);
        end
        @(negedge axi_aclk);
    endtask

    task automatic sendFrame(input int rr, input int len, input int beats, input int corruptOff,
                             input logic [7:0] corruptVal, input logic [10:0] q);
        for (int bt = 0; bt < beats; bt++) begin
            applyStimulus(buildData(rr, len, bt, corruptOff, corruptVal), buildBen(len, bt),
                          (bt == beats - 1), q);
        end
        txIf.tx_valid = 1'b0;
        txIf.tx_last  = 1'b0;
    endtask

    task automatic startRun(input int len, input int npkt, input int q, input int nq);
        @(negedge axi_aclk);
        exp_size    = 16'(len);
        num_pkt     = 16'(npkt);
        qid         = 11'(q);
        num_queue   = 11'(nq);
        control_reg = 32'h2;
        @(negedge axi_aclk);
        control_reg = 32'h0;
    endtask

    task automatic pushExp(input int runId, input int pkt, input int err, input int bytes, input int flag);
        exp_t e;
        e.runId = runId;
        e.pkt   = pkt;
        e.err   = err;
        e.bytes = bytes;
        e.flag  = flag;
        sbQ.push_back(e);
    endtask

    task automatic waitDrained();
        int guard;
        guard = 0;
        while (sbQ.size() != 0 && guard < 200) begin
            @(negedge axi_aclk);
            guard++;
        end
        if (sbQ.size() != 0) begin
            checksTotal++;
            $display("[TB] FAIL done_timeout: %0d runs pending required 0", sbQ.size());
            sbQ.delete();
        end
    endtask

    // Monitor: on each rising chk_done, pop the next expected run result and compare.
    initial begin
        exp_t e;
        forever begin
            @(negedge axi_aclk);
            if (chk_done && !prevDone) begin
                if (sbQ.size() == 0) begin
                    checksTotal++;
                    $display("[TB] FAIL unexpected_done: chk_done %0d with no run pending", chk_done);
                end else begin
                    e = sbQ.pop_front();
                    checkOutput($sformatf("run%0d_pkt_count", e.runId), 32'(pkt_count), 32'(e.pkt));
                    checkOutput($sformatf("run%0d_err_count", e.runId), 32'(err_count), 32'(e.err));
                    checkOutput($sformatf("run%0d_byte_count", e.runId), byte_count, 32'(e.bytes));
                    checkOutput($sformatf("run%0d_err_flag", e.runId), 32'(err_flag), 32'(e.flag));
                end
            end
            prevDone = chk_done;
        end
    end

    initial begin
        txIf.tx_valid = 1'b0;
        txIf.tx_data  = '0;
        txIf.tx_ben   = '0;
        txIf.tx_last  = 1'b0;
        txIf.tx_qid   = 11'd0;
        control_reg   = 32'h0;
        exp_size      = 16'd256;
        num_pkt       = 16'd0;
        qid           = 11'd0;
        num_queue     = 11'd1;
        #1;
        checkOutput("rst_tx_ready", 32'(txIf.tx_ready), 32'd0);
        checkOutput("rst_pkt_count", 32'(pkt_count), 32'd0);
        checkOutput("rst_err_count", 32'(err_count), 32'd0);
        checkOutput("rst_byte_count", byte_count, 32'd0);
        checkOutput("rst_chk_done", 32'(chk_done), 32'd0);
        checkOutput("rst_err_flag", 32'(err_flag), 32'd0);
        repeat (3) @(negedge axi_aclk);
        axi_aresetn = 1'b1;
        @(negedge axi_aclk);

        $display("[TB] run1: num_pkt=0 finishes on start");
        pushExp(1, 0, 0, 0, 0);
        startRun(256, 0, 0, 1);
        waitDrained();

        $display("[TB] run2: clean stream 8 x 256");
        pushExp(2, 8, 0, 2048, 0);
        startRun(256, 8, 0, 1);
        for (int k = 0; k < 8; k++) sendFrame(k % 4, 256, 4, -1, 8'h00, 11'd0);
        waitDrained();

        $display("[TB] run3: byte 100 of packet 3 corrupted");
        pushExp(3, 8, 1, 2048, 1);
        startRun(256, 8, 0, 1);
        for (int k = 0; k < 8; k++) sendFrame(k % 4, 256, 4, (k == 2) ? 100 : -1, 8'h42, 11'd0);
        waitDrained();

        $display("[TB] run4: 100-byte frames with partial last beat");
        pushExp(4, 4, 0, 400, 0);
        startRun(100, 4, 0, 1);
        for (int k = 0; k < 4; k++) sendFrame(k % 4, 100, 2, -1, 8'h00, 11'd0);
        waitDrained();

        $display("[TB] run5: early tx_last then clean frames");
        pushExp(5, 3, 1, 576, 1);
        startRun(256, 3, 0, 1);
        sendFrame(0, 256, 1, -1, 8'h00, 11'd0);
        sendFrame(1, 256, 4, -1, 8'h00, 11'd0);
        sendFrame(2, 256, 4, -1, 8'h00, 11'd0);
        waitDrained();

        $display("[TB] run6: qid rotation with packet 2 on wrong queue");
        pushExp(6, 4, QID_ERR, 1024, QID_ERR);
        startRun(256, 4, 4, 2);
        for (int k = 0; k < 4; k++) sendFrame(k % 4, 256, 4, -1, 8'h00, (k == 1) ? 11'd4 : 11'(4 + (k % 2)));
        waitDrained();

        $display("[TB] run7: clear after a bad single-beat frame");
        pushExp(7, 3, 0, 192, 0);
        startRun(64, 3, 0, 1);
        sendFrame(0, 64, 1, 20, 8'h42, 11'd0);
        @(negedge axi_aclk);
        control_reg = 32'h4;
        @(negedge axi_aclk);
        control_reg = 32'h0;
        for (int k = 1; k < 4; k++) sendFrame(k % 4, 64, 1, -1, 8'h00, 11'd0);
        waitDrained();

        $display("[TB] run8: reset during beat 2 of packet 2");
        startRun(256, 4, 0, 1);
        sendFrame(0, 256, 4, -1, 8'h00, 11'd0);
        checkOutput("pre_reset_pkt_count", 32'(pkt_count), 32'd1);
        applyStimulus(buildData(1, 256, 0, -1, 8'h00), buildBen(256, 0), 1'b0, 11'd0);
        applyStimulus(buildData(1, 256, 1, -1, 8'h00), buildBen(256, 1), 1'b0, 11'd0);
        txIf.tx_data = buildData(1, 256, 2, -1, 8'h00);
        txIf.tx_ben  = buildBen(256, 2);
        #2;
        axi_aresetn = 1'b0;
        #1;
        checkOutput("mid_rst_tx_ready", 32'(txIf.tx_ready), 32'd0);
        checkOutput("mid_rst_pkt_count", 32'(pkt_count), 32'd0);
        checkOutput("mid_rst_err_count", 32'(err_count), 32'd0);
        checkOutput("mid_rst_byte_count", byte_count, 32'd0);
        checkOutput("mid_rst_chk_done", 32'(chk_done), 32'd0);
        checkOutput("mid_rst_err_flag", 32'(err_flag), 32'd0);
        txIf.tx_valid = 1'b0;
        @(negedge axi_aclk);
        axi_aresetn = 1'b1;
        repeat (2) @(negedge axi_aclk);
        checkOutput("post_rst_pkt_count", 32'(pkt_count), 32'd0);
        checkOutput("post_rst_byte_count", byte_count, 32'd0);

        $display("[TB] run9: clean run after reset");
        pushExp(9, 2, 0, 512, 0);
        startRun(256, 2, 0, 1);
        for (int k = 0; k < 2; k++) sendFrame(k % 4, 256, 4, -1, 8'h00, 11'd0);
        waitDrained();

        repeat (2) @(negedge axi_aclk);
        $display("%0d/%0d checks passed", checksPassed, checksTotal);
        $finish;
    end
endmodule
